// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared clip-space types and fp32 ordering helpers
package gfx_pkg;

  typedef logic [3:0][31:0] vertex_t;
  typedef logic [5:0] outcode_t;
  typedef enum logic [1:0] {
    CULL_TRIVIAL = 2'b00,
    CULL_STRICT  = 2'b01,
    CULL_BYPASS  = 2'b10
  } cull_mode_t;

  function automatic logic fp_is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hff) && (f[22:0] != 23'd0);
  endfunction

  // Unsigned key whose integer order follows IEEE order; -0 folds onto +0.
  function automatic logic [31:0] fp_key(input logic [31:0] f);
    logic [31:0] g;
    g = (f[30:0] == 31'd0) ? 32'd0 : f;
    return g[31] ? ~g : (g | 32'h8000_0000);
  endfunction

  function automatic cull_mode_t decode_cull_mode(input logic [1:0] m);
    if (m == 2'b00) return CULL_TRIVIAL;
    if (m == 2'b10) return CULL_BYPASS;
    return CULL_STRICT;
  endfunction

endpackage

// File: rtl/fp32_outcode.sv
// rtl/fp32_outcode.sv - registered 6-bit clip outcode of one vertex against +/-w
module fp32_outcode
  import gfx_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [3:0][31:0] vertex_in,
  output logic             valid_out,
  output logic [5:0]       outcode_out
);

  outcode_t    oc;
  logic [31:0] key_w;
  logic [31:0] key_neg_w;
  logic [31:0] key_c;
  logic        w_nan;

  always_comb begin
    oc        = '0;
    key_c     = '0;
    w_nan     = fp_is_nan(vertex_in[3]);
    key_w     = fp_key(vertex_in[3]);
    key_neg_w = fp_key({~vertex_in[3][31], vertex_in[3][30:0]});
    for (int i = 0; i < 3; i++) begin
      key_c = fp_key(vertex_in[i]);
      if (w_nan || fp_is_nan(vertex_in[i])) begin
        oc[2*i +: 2] = 2'b11;
      end else begin
        oc[2*i]     = key_c > key_w;
        oc[2*i + 1] = key_c < key_neg_w;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) valid_out <= 1'b0;
    else        valid_out <= valid_in;
    outcode_out <= oc;
  end

endmodule

// File: rtl/triangle_cull_stream.sv
// rtl/triangle_cull_stream.sv - triangle assembly, cull classification and replay FIFO
module triangle_cull_stream
  import gfx_pkg::*;
#(
  parameter int ATTR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [1:0]            cull_mode_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [3:0][31:0]      vertex_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [3:0][31:0]      vertex_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  partial_out,
  output logic [CNT_WIDTH-1:0]  tri_accepted_out,
  output logic [CNT_WIDTH-1:0]  tri_rejected_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1) + 1;

  logic [1:0]            in_idx;
  logic                  in_fire;
  logic                  reserve;

  logic                  s1_valid;
  outcode_t              s1_oc;
  vertex_t               s1_vtx;
  logic [ATTR_WIDTH-1:0] s1_attr;
  logic [1:0]            s1_idx;
  cull_mode_t            s1_mode;

  vertex_t               asm_vtx  [3];
  logic [ATTR_WIDTH-1:0] asm_attr [3];
  outcode_t              asm_oc   [2];
  outcode_t              oc_or, oc_and;
  logic                  cls_accept, cls_partial;

  logic                  s2_valid, s2_accept, s2_partial;

  vertex_t               fifo_vtx     [DEPTH][3];
  logic [ATTR_WIDTH-1:0] fifo_attr    [DEPTH][3];
  logic                  fifo_partial [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [OCC_W-1:0]      fifo_count, reserved;
  logic [1:0]            out_idx;
  logic                  push, pop, out_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Vertex 0 needs a slot reserved; vertices 1 and 2 finish an already-reserved triangle.
  assign ready_out = !rst_in && ((in_idx != 2'd0) || ((fifo_count + reserved) < OCC_W'(DEPTH)));
  assign in_fire   = valid_in && ready_out;
  assign reserve   = in_fire && (in_idx == 2'd0);

  fp32_outcode u_outcode (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .valid_in    (in_fire),
    .vertex_in   (vertex_in),
    .valid_out   (s1_valid),
    .outcode_out (s1_oc)
  );

  // Vertex 2 is classified straight from its fresh outcode; 0 and 1 come from assembly.
  always_comb begin
    oc_or       = asm_oc[0] | asm_oc[1] | s1_oc;
    oc_and      = asm_oc[0] & asm_oc[1] & s1_oc;
    cls_accept  = 1'b0;
    cls_partial = 1'b0;
    case (s1_mode)
      CULL_TRIVIAL: begin
        cls_accept  = (oc_and == '0);
        cls_partial = (oc_or != '0);
      end
      CULL_BYPASS: begin
        cls_accept  = 1'b1;
        cls_partial = (oc_or != '0);
      end
      default: begin
        cls_accept  = (oc_or == '0);
        cls_partial = 1'b0;
      end
    endcase
  end

  assign push      = s2_valid && s2_accept;
  assign valid_out = (fifo_count != '0);
  assign out_fire  = valid_out && ready_in;
  assign pop       = out_fire && (out_idx == 2'd2);

  assign vertex_out  = fifo_vtx[rd_ptr][out_idx];
  assign attr_out    = fifo_attr[rd_ptr][out_idx];
  assign partial_out = valid_out && fifo_partial[rd_ptr];

  // Datapath storage: qualified by control state, so no reset needed.
  always_ff @(posedge clk_in) begin
    if (in_fire) begin
      s1_vtx  <= vertex_in;
      s1_attr <= attr_in;
      s1_idx  <= in_idx;
      if (in_idx == 2'd2) s1_mode <= decode_cull_mode(cull_mode_in);
    end
    if (s1_valid) begin
      asm_vtx[s1_idx]  <= s1_vtx;
      asm_attr[s1_idx] <= s1_attr;
      if (s1_idx != 2'd2) asm_oc[s1_idx[0]] <= s1_oc;
    end
    s2_accept  <= cls_accept;
    s2_partial <= cls_partial;
    if (push) begin
      for (int k = 0; k < 3; k++) begin
        fifo_vtx[wr_ptr][k]  <= asm_vtx[k];
        fifo_attr[wr_ptr][k] <= asm_attr[k];
      end
      fifo_partial[wr_ptr] <= s2_partial;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_idx           <= 2'd0;
      s2_valid         <= 1'b0;
      reserved         <= '0;
      fifo_count       <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      out_idx          <= 2'd0;
      tri_accepted_out <= '0;
      tri_rejected_out <= '0;
    end else begin
      if (in_fire) in_idx <= (in_idx == 2'd2) ? 2'd0 : in_idx + 2'd1;
      s2_valid <= s1_valid && (s1_idx == 2'd2);
      // A write moves the reservation into occupancy; a reject simply frees it.
      reserved   <= reserved + OCC_W'(reserve) - OCC_W'(s2_valid);
      fifo_count <= fifo_count + OCC_W'(push) - OCC_W'(pop);
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (out_fire) out_idx <= (out_idx == 2'd2) ? 2'd0 : out_idx + 2'd1;
      if (push) tri_accepted_out <= tri_accepted_out + CNT_WIDTH'(1);
      if (s2_valid && !s2_accept) tri_rejected_out <= tri_rejected_out + CNT_WIDTH'(1);
    end
  end

endmodule
